// File: rtl/cq_credit.sv
// cq_credit: credit-throttled FIFO completion queue from execute lanes to the CDB.
// Optional same-cycle bypass while the queue is empty: define CQ_BYPASS_EN.
package cq_pkg;
    typedef struct packed {
        logic [5:0] index;
        logic       valid;
    } tag_t;

    typedef struct packed {
        logic        valid;
        tag_t        target;
        logic [5:0]  rob_index;
        logic [31:0] result;
    } result_packet_t;

    typedef struct packed {
        tag_t        tag;
        logic [5:0]  rob_index;
        logic [31:0] value;
    } complete_packet_t;
endpackage

module cq_credit
    import cq_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int C_WIDTH = 3,
    parameter int E_WIDTH = 7
) (
    input  logic                             clock,
    input  logic                             reset,
    input  result_packet_t   [E_WIDTH-1:0]   execute,
    output logic             [E_WIDTH-1:0]   stall,
    input  logic [$clog2(C_WIDTH+1)-1:0]     cdb_credit,
    input  logic                             flush,
    output complete_packet_t [C_WIDTH-1:0]   complete,
    output logic [$clog2(SIZE+1)-1:0]        count
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int NW = $clog2(SIZE+1);

    complete_packet_t   mem [SIZE];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [E_WIDTH-1:0] wr_en;
    logic [AW-1:0]      wr_idx [E_WIDTH];
    int                 free_n;
    int                 cred_n;
    int                 deq_n;
    int                 enq_n;
`ifdef CQ_BYPASS_EN
    int                 byp_n;
`endif
    logic               unused_target;

    // Ring wrap is explicit so SIZE need not be a power of two.
    function automatic logic [AW-1:0] ring_add(
        input logic [AW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= SIZE) s = s - SIZE;
        return AW'(s);
    endfunction

    function automatic complete_packet_t to_cpl(input result_packet_t r);
        complete_packet_t p;
        p.tag.index = r.target.index;
        p.tag.valid = 1'b1;
        p.rob_index = r.rob_index;
        p.value     = r.result;
        return p;
    endfunction

    always_comb begin
        unused_target = 1'b0;
        for (int i = 0; i < E_WIDTH; i++)
            unused_target = unused_target ^ execute[i].target.valid;
    end

    always_comb begin
        free_n = SIZE - int'(count);
        cred_n = (int'(cdb_credit) > C_WIDTH) ? C_WIDTH : int'(cdb_credit);
        deq_n  = (int'(count) < cred_n) ? int'(count) : cred_n;
        enq_n  = 0;
`ifdef CQ_BYPASS_EN
        byp_n  = 0;
`endif
        complete = '0;
        wr_en    = '0;
        for (int i = 0; i < E_WIDTH; i++) begin
            stall[i]  = (i >= free_n);
            wr_idx[i] = '0;
        end
        for (int k = 0; k < C_WIDTH; k++)
            if (k < deq_n) complete[k] = mem[ring_add(head, k)];
        for (int i = 0; i < E_WIDTH; i++) begin
            if (execute[i].valid && !stall[i]) begin
`ifdef CQ_BYPASS_EN
                if (count == '0 && byp_n < cred_n) begin
                    complete[byp_n] = to_cpl(execute[i]);
                    byp_n = byp_n + 1;
                end else begin
`else
                begin
`endif
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = ring_add(tail, enq_n);
                    enq_n     = enq_n + 1;
                end
            end
        end
        if (flush) complete = '0;
    end

    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            for (int i = 0; i < E_WIDTH; i++)
                if (wr_en[i]) mem[wr_idx[i]] <= to_cpl(execute[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= ring_add(head, deq_n);
            tail  <= ring_add(tail, enq_n);
            count <= NW'(int'(count) + enq_n - deq_n);
        end
    end
endmodule

// File: tb/tb_cq_credit.sv
// Scoreboard bench for cq_credit: 32x7x3 main instance and a 5x2x2 wrap instance.
// Expected packets are queued at acceptance and popped by per-instance monitors.
module tb_cq_credit;
    import cq_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    result_packet_t   [6:0] exe    = '0;
    logic             [6:0] stall;
    logic             [1:0] credit = '0;
    logic                   flush  = 1'b0;
    complete_packet_t [2:0] cmp;
    logic             [5:0] count;

    result_packet_t   [1:0] exb    = '0;
    logic             [1:0] stallb;
    logic             [1:0] credb  = '0;
    logic                   flushb = 1'b0;
    complete_packet_t [1:0] cmpb;
    logic             [2:0] countb;

    int nrun = 0;
    int nfail = 0;
    int seq = 1;
    int seqb = 0;
    complete_packet_t exq[$];
    complete_packet_t exqb[$];

    cq_credit #(.SIZE(32), .C_WIDTH(3), .E_WIDTH(7)) dut_a (
        .clock(clock), .reset(reset), .execute(exe), .stall(stall),
        .cdb_credit(credit), .flush(flush), .complete(cmp), .count(count)
    );

    cq_credit #(.SIZE(5), .C_WIDTH(2), .E_WIDTH(2)) dut_b (
        .clock(clock), .reset(reset), .execute(exb), .stall(stallb),
        .cdb_credit(credb), .flush(flushb), .complete(cmpb), .count(countb)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        nrun++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic result_packet_t mk(input bit v, input int tag, input int rob);
        result_packet_t r;
        r.valid        = v;
        r.target.index = 6'(tag);
        r.target.valid = 1'b1;
        r.rob_index    = 6'(rob);
        r.result       = 32'h5A00_0000 + 32'(rob * 3);
        return r;
    endfunction

    function automatic complete_packet_t to_cpl(input result_packet_t r);
        complete_packet_t p;
        p.tag.index = r.target.index;
        p.tag.valid = 1'b1;
        p.rob_index = r.rob_index;
        p.value     = r.result;
        return p;
    endfunction

    always @(negedge clock) begin : mon_a
        int cs;
        int n;
        complete_packet_t e [3];
        for (int k = 0; k < 3; k++) e[k] = '0;
        cs = (int'(credit) > 3) ? 3 : int'(credit);
        n = 0;
        if (reset && !flush) begin
            n = (exq.size() < cs) ? exq.size() : cs;
            for (int k = 0; k < n; k++) e[k] = exq[k];
`ifdef CQ_BYPASS_EN
            if (exq.size() == 0) begin
                int nb;
                nb = 0;
                for (int i = 0; i < 7; i++)
                    if (exe[i].valid && nb < cs) begin
                        e[nb] = to_cpl(exe[i]);
                        nb++;
                    end
            end
`endif
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("cpl_a[%0d]", k), 64'(cmp[k]), 64'(e[k]));
        for (int k = 0; k < n; k++) void'(exq.pop_front());
    end

    always @(negedge clock) begin : mon_b
        int cs;
        int n;
        complete_packet_t e [2];
        for (int k = 0; k < 2; k++) e[k] = '0;
        cs = (int'(credb) > 2) ? 2 : int'(credb);
        n = 0;
        if (reset) begin
            n = (exqb.size() < cs) ? exqb.size() : cs;
            for (int k = 0; k < n; k++) e[k] = exqb[k];
`ifdef CQ_BYPASS_EN
            if (exqb.size() == 0) begin
                int nb;
                nb = 0;
                for (int i = 0; i < 2; i++)
                    if (exb[i].valid && nb < cs) begin
                        e[nb] = to_cpl(exb[i]);
                        nb++;
                    end
            end
`endif
        end
        for (int k = 0; k < 2; k++)
            check($sformatf("cpl_b[%0d]", k), 64'(cmpb[k]), 64'(e[k]));
        check("count_b_le5", 64'(countb > 3'd5), 64'd0);
        for (int k = 0; k < n; k++) void'(exqb.pop_front());
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input logic [6:0] vm, input int cr, input bit fl);
        int free;
        int nb;
        logic [6:0] es;
        result_packet_t acc[$];
        for (int i = 0; i < 7; i++) exe[i] = mk(vm[i], seq + i, seq + 1 + i);
        seq += 7;
        credit = 2'(cr);
        flush = fl;
        free = 32 - exq.size();
        for (int i = 0; i < 7; i++) es[i] = (i >= free);
        for (int i = 0; i < 7; i++)
            if (vm[i] && !es[i]) acc.push_back(exe[i]);
        nb = 0;
`ifdef CQ_BYPASS_EN
        if (exq.size() == 0 && !fl)
            nb = (acc.size() < cr) ? acc.size() : cr;
`endif
        #1;
        check("stall_a", 64'(stall), 64'(es));
        check("count_a", 64'(count), 64'(exq.size()));
        @(posedge clock);
        if (fl) exq.delete();
        else for (int j = nb; j < acc.size(); j++) exq.push_back(to_cpl(acc[j]));
        #1;
        exe = '0;
        flush = 1'b0;
    endtask

    task automatic drive_b(input logic [1:0] vm, input int cr);
        int free;
        int nb;
        int cs;
        logic [1:0] es;
        result_packet_t acc[$];
        for (int i = 0; i < 2; i++) exb[i] = mk(vm[i], seqb + i, seqb + i);
        seqb += 2;
        credb = 2'(cr);
        free = 5 - exqb.size();
        for (int i = 0; i < 2; i++) es[i] = (i >= free);
        for (int i = 0; i < 2; i++)
            if (vm[i] && !es[i]) acc.push_back(exb[i]);
        cs = (cr > 2) ? 2 : cr;
        nb = 0;
`ifdef CQ_BYPASS_EN
        if (exqb.size() == 0) nb = (acc.size() < cs) ? acc.size() : cs;
`endif
        #1;
        check("stall_b", 64'(stallb), 64'(es));
        check("count_b", 64'(countb), 64'(exqb.size()));
        @(posedge clock);
        for (int j = nb; j < acc.size(); j++) exqb.push_back(to_cpl(acc[j]));
        #1;
        exb = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        reset = 1'b1;

        // first packet latency and in-order delivery of tags 1..3
        drive(7'h7F, 3, 1'b0);
        drive(7'h00, 3, 1'b0);
        for (int t = 0; t < 20 && exq.size() > 0; t++) drive(7'h00, 3, 1'b0);

        // fill to full with no credit
        repeat (7) drive(7'h7F, 0, 1'b0);
        drive(7'h00, 1, 1'b0);
        drive(7'h00, 0, 1'b0);
        for (int t = 0; t < 20 && exq.size() > 10; t++) drive(7'h00, 3, 1'b0);

        // flush with 10 entries and a full lane set
        drive(7'h7F, 3, 1'b1);
        drive(7'h00, 0, 1'b0);

        // empty queue, lanes 0..4
        drive(7'h1F, 3, 1'b0);
        drive(7'h00, 3, 1'b0);
        drive(7'h00, 3, 1'b0);

        // asynchronous reset in mid-cycle
        drive(7'h7F, 0, 1'b0);
        drive(7'h7F, 0, 1'b0);
        credit = '0;
        #2;
        reset = 1'b0;
        exq.delete();
        exqb.delete();
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_cpl", 64'(cmp[0].tag.valid | cmp[1].tag.valid |
                                cmp[2].tag.valid), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(7'h03, 3, 1'b0);
        drive(7'h00, 3, 1'b0);
        drive(7'h00, 3, 1'b0);

        // small ring: fill, then random traffic with wrap
        repeat (4) drive_b(2'b11, 0);
        for (int t = 0; t < 40; t++)
            drive_b(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        for (int t = 0; t < 10 && exqb.size() > 0; t++) drive_b(2'b00, 2);
        drive_b(2'b00, 2);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
